// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I opcode constants and sequencer state encodings shared by control and sequencer.
package rv32_pkg;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts memory wait cycles; o_tc flags the wait cycle that reaches MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en) r_cnt <= r_cnt + 1'b1;
  assign o_tc = i_en && (r_cnt == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle RV32I FSM sharing one handshaked memory port between fetch and load/store.
module multicycle_sequencer
  import rv32_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             ctl_regwen,
  input  logic [1:0]       ctl_memwen,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_addr_sel,
  output logic [1:0]       mem_we,
  output logic             ir_load,
  output logic             mdr_load,
  output logic             pc_write,
  output logic             reg_we,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_instret;
  logic w_tc, w_is_st, w_is_ls;
  assign w_is_st = opcode == OP_STORE;
  assign w_is_ls = w_is_st || opcode == OP_LOAD;
  // Any state change restarts the wait count, so each access gets a fresh budget.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_next != r_state),
    .i_en (mem_req && !mem_ready),
    .o_tc (w_tc)
  );
  always_comb begin
    w_next       = r_state;
    mem_req      = 1'b0;
    mem_addr_sel = 1'b0;
    mem_we       = 2'b00;
    ir_load      = 1'b0;
    mdr_load     = 1'b0;
    pc_write     = 1'b0;
    reg_we       = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
        w_next  = mem_ready ? S_DECODE : w_tc ? S_TRAP : S_FETCH;
      end
      S_DECODE: w_next = is_legal(opcode) ? S_EXEC : S_TRAP;
      S_EXEC:   w_next = w_is_ls ? S_MEM : S_WB;
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = w_is_st ? ctl_memwen : 2'b00;
        mdr_load     = mem_ready && !w_is_st;
        pc_write     = mem_ready && w_is_st;
        w_next       = mem_ready ? (w_is_st ? S_FETCH : S_WB) : w_tc ? S_TRAP : S_MEM;
      end
      S_WB: begin
        reg_we   = ctl_regwen;
        pc_write = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_TRAP;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state   <= w_next;
      r_instret <= pc_write ? r_instret + 1'b1 : r_instret;
    end
  assign trap    = r_state == S_TRAP;
  assign state   = r_state;
  assign instret = r_instret;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed self-checking bench for multicycle_sequencer (MEM_TIMEOUT=4, CNT_W=4).
module tb_multicycle_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic ctl_regwen = 1'b0, mem_ready = 1'b0;
  logic [1:0] ctl_memwen = 2'b00;
  logic mem_req, mem_addr_sel, ir_load, mdr_load, pc_write, reg_we, trap;
  logic [1:0] mem_we;
  logic [2:0] state;
  logic [3:0] instret;
  logic [11:0] obs;
  int n_pass = 0, n_chk = 0;
  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, T = 3'd7;
  localparam logic [6:0] ADDI = 7'b0010011, LW = 7'b0000011, SX = 7'b0100011, ECALL = 7'b1110011;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ctl_regwen(ctl_regwen), .ctl_memwen(ctl_memwen),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_addr_sel(mem_addr_sel), .mem_we(mem_we),
    .ir_load(ir_load), .mdr_load(mdr_load), .pc_write(pc_write), .reg_we(reg_we),
    .trap(trap), .state(state), .instret(instret)
  );

  assign obs = {state, mem_req, mem_addr_sel, mem_we, ir_load, mdr_load, pc_write, reg_we, trap};

  function automatic logic [11:0] v(input logic [2:0] s, input logic req, sel, input logic [1:0] we,
                                    input logic ir, mdr, pcw, rw, tr);
    return {s, req, sel, we, ir, mdr, pcw, rw, tr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  task automatic cyc(input string tag, input logic [11:0] e);
    #1;
    chk(tag, {20'd0, obs}, {20'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic alu;
    opcode = ADDI;
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_outs", {20'd0, obs}, {20'd0, v(F, 1, 0, 2'b00, 0, 0, 0, 0, 0)});
    chk("reset_instret", {28'd0, instret}, 32'd0);
    opcode = ADDI; ctl_regwen = 1'b1; ctl_memwen = 2'b11; mem_ready = 1'b1;
    cyc("t1_fetch", v(F, 1, 0, 2'b00, 1, 0, 0, 0, 0));
    cyc("t1_decode", v(D, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    cyc("t1_exec", v(E, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    cyc("t1_wb", v(W, 0, 0, 2'b00, 0, 0, 1, 1, 0));
    chk("t1_instret", {28'd0, instret}, 32'd1);
    opcode = LW;
    cyc("t2_fetch", v(F, 1, 0, 2'b00, 1, 0, 0, 0, 0));
    cyc("t2_decode", v(D, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    cyc("t2_exec", v(E, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    cyc("t2_mem", v(M, 1, 1, 2'b00, 0, 1, 0, 0, 0));
    cyc("t2_wb", v(W, 0, 0, 2'b00, 0, 0, 1, 1, 0));
    chk("t2_instret", {28'd0, instret}, 32'd2);
    opcode = SX; ctl_memwen = 2'b01;
    cyc("t3_fetch", v(F, 1, 0, 2'b00, 1, 0, 0, 0, 0));
    cyc("t3_decode", v(D, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    cyc("t3_exec", v(E, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    mem_ready = 1'b0;
    repeat (3) cyc("t3_wait", v(M, 1, 1, 2'b01, 0, 0, 0, 0, 0));
    mem_ready = 1'b1;
    cyc("t3_done", v(M, 1, 1, 2'b01, 0, 0, 1, 0, 0));
    chk("t3_next_fetch", {29'd0, state}, {29'd0, F});
    chk("t3_instret", {28'd0, instret}, 32'd3);
    ctl_memwen = 2'b11;
    cyc("t6_fetch", v(F, 1, 0, 2'b00, 1, 0, 0, 0, 0));
    cyc("t6_decode", v(D, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    cyc("t6_exec", v(E, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    mem_ready = 1'b0;
    cyc("t6_mem", v(M, 1, 1, 2'b11, 0, 0, 0, 0, 0));
    reset_pulse();
    #1;
    chk("t6_rst_state", {20'd0, obs}, {20'd0, v(F, 1, 0, 2'b00, 0, 0, 0, 0, 0)});
    chk("t6_rst_instret", {28'd0, instret}, 32'd0);
    repeat (15) alu();
    chk("t6_instret15", {28'd0, instret}, 32'd15);
    alu();
    chk("t6_wrap", {28'd0, instret}, 32'd0);
    chk("t6_wrap_state", {29'd0, state}, {29'd0, F});
    opcode = ECALL; mem_ready = 1'b1;
    cyc("t4_fetch", v(F, 1, 0, 2'b00, 1, 0, 0, 0, 0));
    cyc("t4_decode", v(D, 0, 0, 2'b00, 0, 0, 0, 0, 0));
    for (int i = 0; i < 20; i++) cyc("t4_trap_hold", v(T, 0, 0, 2'b00, 0, 0, 0, 0, 1));
    mem_ready = 1'b0;
    reset_pulse();
    #1;
    chk("t4_rst_clear", {20'd0, obs}, {20'd0, v(F, 1, 0, 2'b00, 0, 0, 0, 0, 0)});
    opcode = ADDI;
    repeat (4) cyc("t5_wait", v(F, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    #1;
    chk("t5_timeout", {20'd0, obs}, {20'd0, v(T, 0, 0, 2'b00, 0, 0, 0, 0, 1)});
    reset_pulse();
    repeat (3) cyc("t5b_wait", v(F, 1, 0, 2'b00, 0, 0, 0, 0, 0));
    mem_ready = 1'b1;
    cyc("t5b_ready_wins", v(F, 1, 0, 2'b00, 1, 0, 0, 0, 0));
    #1;
    chk("t5b_decode", {20'd0, obs}, {20'd0, v(D, 0, 0, 2'b00, 0, 0, 0, 0, 0)});
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
